// File: rtl/data_ram_responder_pkg.sv
// data_ram_responder_pkg: shared encodings for the MEM-stage data RAM responder
package data_ram_responder_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/data_ram_responder_if.sv
// data_ram_responder_if: MEM-stage request/response bundle between initiator and data RAM
interface data_ram_responder_if;
  logic enable;
  logic rw;
  logic [1:0] data_size;
  logic sign_ext;
  logic [31:0] address_in;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic moc;
  logic error;
  logic busy;
  modport master (
    output enable, rw, data_size, sign_ext, address_in, data_in,
    input data_out, moc, error, busy
  );
  modport slave (
    input enable, rw, data_size, sign_ext, address_in, data_in,
    output data_out, moc, error, busy
  );
endinterface

// File: rtl/data_ram_responder_byte_lane_formatter.sv
// byte_lane_formatter: big-endian lane mapping, load extension and access legality check
module byte_lane_formatter
  import data_ram_responder_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        err,
  output logic [31:0] rdata,
  output logic [3:0]  lane_we,
  output logic [31:0] wword
);
  logic bs;
  logic hs;
  // rword/wword lane 0 (bits 31:24) is the byte at addr itself
  always_comb begin
    err = size == SIZE_RSVD || (size == SIZE_HALF && addr[0]) ||
          (size == SIZE_WORD && addr[1:0] != 2'b00) || (addr >> AW) != 32'd0;
    bs = sign_ext & rword[31];
    hs = sign_ext & rword[31];
    rdata = size == SIZE_BYTE ? {{24{bs}}, rword[31:24]} :
            size == SIZE_HALF ? {{16{hs}}, rword[31:16]} : rword;
    wword = size == SIZE_BYTE ? {wdata[7:0], 24'h0} :
            size == SIZE_HALF ? {wdata[15:0], 16'h0} : wdata;
    lane_we = err ? 4'b0000 : size == SIZE_BYTE ? 4'b0001 :
              size == SIZE_HALF ? 4'b0011 : 4'b1111;
  end
endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder: fixed-latency big-endian byte RAM answering MEM-stage loads/stores with MOC
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_BYTES = 256
) (
  input logic clk,
  input logic rst,
  data_ram_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_BYTES);
  logic [7:0] mem [DEPTH_BYTES];
  logic [1:0] state;
  logic [3:0] cnt;
  logic rw_q;
  logic [1:0] size_q;
  logic sx_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] dout;
  logic err_q;
  logic [AW-1:0] a;
  logic [31:0] rword;
  logic [31:0] rdata;
  logic [31:0] wword;
  logic [3:0] lane_we;
  logic err;
  logic fire;
  assign a = addr_q[AW-1:0];
  assign fire = state == S_BUSY && cnt == 4'd1;
  always_comb begin
    rword = '0;
    for (int i = 0; i < 4; i++) rword[31-8*i -: 8] = mem[a + AW'(i)];
  end
  byte_lane_formatter #(.AW(AW)) u_fmt (
    .size(size_q),
    .sign_ext(sx_q),
    .addr(addr_q),
    .wdata(data_q),
    .rword(rword),
    .err(err),
    .rdata(rdata),
    .lane_we(lane_we),
    .wword(wword)
  );
  // array is never reset; state is async-reset to IDLE so a reset kills any pending store
  always_ff @(posedge clk) begin
    if (fire && rw_q == RW_WRITE)
      for (int i = 0; i < 4; i++)
        if (lane_we[i]) mem[a + AW'(i)] <= wword[31-8*i -: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      rw_q <= RW_WRITE;
      size_q <= SIZE_BYTE;
      sx_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      dout <= '0;
      err_q <= 1'b0;
    end else if (state == S_IDLE) begin
      if (bus.enable) begin
        state <= S_BUSY;
        cnt <= 4'(WAIT_CYCLES);
        rw_q <= bus.rw;
        size_q <= bus.data_size;
        sx_q <= bus.sign_ext;
        addr_q <= bus.address_in;
        data_q <= bus.data_in;
      end
    end else if (state == S_BUSY) begin
      cnt <= cnt - 4'd1;
      if (fire) begin
        state <= S_DONE;
        err_q <= err;
        dout <= rw_q == RW_READ ? (err ? 32'd0 : rdata) : dout;
      end
    end else begin
      state <= S_IDLE;
      err_q <= 1'b0;
    end
  end
  assign bus.moc = state == S_DONE;
  assign bus.error = bus.moc & err_q;
  assign bus.busy = state != S_IDLE;
  assign bus.data_out = dout;
endmodule
